// File: rtl/imem_loader.sv
// Boot loader: assembles a length-prefixed, XOR-checked byte stream into big-endian
// words, writes them to instruction memory and releases the CPU only after a clean load.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  input  logic        load_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_resetN,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {HDR0, HDR1, DATA, CSUM, RUN, ERR} state_t;

  // Header may legally request exactly the full memory, so compare in 17 bits.
  localparam logic [16:0] CAP = 17'(1) << ADDR_W;

  state_t      state, state_nxt;
  logic [15:0] cnt_n;
  logic [1:0]  byte_cnt;
  logic [16:0] word_idx;
  logic [23:0] asm_q;
  logic [7:0]  csum;
  logic        accept;
  logic [16:0] n_hdr;
  logic        last_word;

  assign rx_ready  = (state != RUN) && (state != ERR);
  assign accept    = rx_valid && rx_ready;
  assign n_hdr     = {1'b0, cnt_n[15:8], rx_data};
  assign last_word = (word_idx + 17'd1) == {1'b0, cnt_n};

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= HDR0;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HDR0: if (accept) state_nxt = HDR1;
      HDR1: if (accept) begin
        if (n_hdr == 17'd0)   state_nxt = CSUM;
        else if (n_hdr > CAP) state_nxt = ERR;
        else                  state_nxt = DATA;
      end
      DATA: if (accept && byte_cnt == 2'd3 && last_word) state_nxt = CSUM;
      CSUM: if (accept) state_nxt = (rx_data == csum) ? RUN : ERR;
      RUN, ERR: if (load_req) state_nxt = HDR0;
      default: state_nxt = HDR0;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_resetN <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      cnt_n      <= '0;
      byte_cnt   <= '0;
      word_idx   <= '0;
      asm_q      <= '0;
      csum       <= '0;
    end else begin
      mem_we     <= 1'b0;
      // Status follows the next state so it lands the cycle after the deciding byte.
      cpu_resetN <= (state_nxt == RUN);
      done       <= (state_nxt == RUN);
      error      <= (state_nxt == ERR);
      case (state)
        HDR0: if (accept) cnt_n[15:8] <= rx_data;
        HDR1: if (accept) cnt_n[7:0] <= rx_data;
        DATA: if (accept) begin
          csum     <= csum ^ rx_data;
          byte_cnt <= byte_cnt + 2'd1;
          asm_q    <= {asm_q[15:0], rx_data};
          if (byte_cnt == 2'd3) begin
            mem_we    <= 1'b1;
            mem_wdata <= {asm_q, rx_data};
            mem_addr  <= {{(30-ADDR_W){1'b0}}, word_idx[ADDR_W-1:0], 2'b00};
            word_idx  <= word_idx + 17'd1;
          end
        end
        RUN, ERR: if (load_req) begin
          cnt_n    <= '0;
          byte_cnt <= '0;
          word_idx <= '0;
          asm_q    <= '0;
          csum     <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a default-size instance and a 4-word instance
// share one stimulus stream; each task checks the instance it targets.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        resetN, rx_valid, load_req;
  logic [7:0]  rx_data;
  logic        rx_ready, mem_we, cpu_resetN, done, error;
  logic [31:0] mem_addr, mem_wdata;
  logic        rx_ready2, mem_we2, cpu_resetN2, done2, error2;
  logic [31:0] mem_addr2, mem_wdata2;

  int checks = 0;
  int errors = 0;

  logic [31:0] wa[$], wd[$], wa2[$], wd2[$];
  logic [31:0] img2 [4];
  logic [31:0] img4 [4];

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(8)) dut (
    .clk(clk), .resetN(resetN), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .load_req(load_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_resetN(cpu_resetN),
    .done(done), .error(error)
  );

  imem_loader #(.ADDR_W(2)) dut2 (
    .clk(clk), .resetN(resetN), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready2), .load_req(load_req), .mem_we(mem_we2),
    .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .cpu_resetN(cpu_resetN2),
    .done(done2), .error(error2)
  );

  // Write log, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we)  begin wa.push_back(mem_addr);   wd.push_back(mem_wdata);   end
    if (mem_we2) begin wa2.push_back(mem_addr2); wd2.push_back(mem_wdata2); end
  end

  task automatic clear_log();
    wa.delete(); wd.delete(); wa2.delete(); wd2.delete();
  endtask

  task automatic do_reset();
    rx_valid = 1'b0; rx_data = 8'h00; load_req = 1'b0; resetN = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    resetN = 1'b1;
    clear_log();
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = b;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); rx_valid = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_load();
    @(negedge clk); load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
  endtask

  // Header, payload, then XOR of payload bytes (optionally corrupted by flip).
  task automatic send_stream(input int n, input logic [31:0] w [4], input int gap,
                             input logic [7:0] flip);
    logic [7:0] cs;
    logic [15:0] nn;
    cs = 8'h00;
    nn = 16'(n);
    send_byte(nn[15:8]); idle(gap);
    send_byte(nn[7:0]);  idle(gap);
    for (int i = 0; i < n; i++)
      for (int b = 3; b >= 0; b--) begin
        cs = cs ^ w[i][8*b +: 8];
        send_byte(w[i][8*b +: 8]); idle(gap);
      end
    send_byte(cs ^ flip);
    idle(1);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (rx_ready !== 1'b1)    begin errors++; $display("FAIL reset_rx_ready got %0b exp 1", rx_ready); end
    checks++; if (mem_we !== 1'b0)      begin errors++; $display("FAIL reset_mem_we got %0b exp 0", mem_we); end
    checks++; if (mem_addr !== 32'h0)   begin errors++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0)  begin errors++; $display("FAIL reset_mem_wdata got %h exp 0", mem_wdata); end
    checks++; if ({cpu_resetN, done, error} !== 3'b000) begin errors++; $display("FAIL reset_status got %b exp 000", {cpu_resetN, done, error}); end
  endtask

  task automatic check_two_writes(input string tag);
    checks++;
    if (wa.size() != 2) begin errors++; $display("FAIL %s_write_count got %0d exp 2", tag, wa.size()); end
    else begin
      if (wa[0] !== 32'h0 || wd[0] !== 32'h20080005) begin errors++; $display("FAIL %s_write0 got %h/%h exp 0/20080005", tag, wa[0], wd[0]); end
      checks++;
      if (wa[1] !== 32'h4 || wd[1] !== 32'hAC010004) begin errors++; $display("FAIL %s_write1 got %h/%h exp 4/ac010004", tag, wa[1], wd[1]); end
    end
  endtask

  task automatic test_basic();
    do_reset();
    send_stream(2, img2, 0, 8'h00);
    check_two_writes("basic");
    checks++; if ({cpu_resetN, done, error} !== 3'b110) begin errors++; $display("FAIL basic_status got %b exp 110", {cpu_resetN, done, error}); end
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL basic_rx_ready got %0b exp 0", rx_ready); end
    // Bytes offered while running must be ignored.
    for (int i = 0; i < 6; i++) send_byte(8'h55);
    idle(2);
    checks++; if (wa.size() != 2 || done !== 1'b1) begin errors++; $display("FAIL run_ignore got writes=%0d done=%0b exp 2/1", wa.size(), done); end
  endtask

  task automatic test_bad_csum();
    do_reset();
    send_stream(2, img2, 0, 8'h01);
    check_two_writes("badcs");
    checks++; if ({cpu_resetN, done, error} !== 3'b001) begin errors++; $display("FAIL badcs_status got %b exp 001", {cpu_resetN, done, error}); end
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL badcs_rx_ready got %0b exp 0", rx_ready); end
    pulse_load();
    checks++; if ({rx_ready, cpu_resetN, done, error} !== 4'b1000) begin errors++; $display("FAIL reload_state got %b exp 1000", {rx_ready, cpu_resetN, done, error}); end
    clear_log();
    send_stream(2, img2, 0, 8'h00);
    check_two_writes("reload");
    checks++; if ({cpu_resetN, done, error} !== 3'b110) begin errors++; $display("FAIL reload_status got %b exp 110", {cpu_resetN, done, error}); end
  endtask

  task automatic test_empty();
    do_reset();
    send_stream(0, img2, 0, 8'h00);
    checks++; if (wa.size() != 0 || done !== 1'b1) begin errors++; $display("FAIL empty_ok got writes=%0d done=%0b exp 0/1", wa.size(), done); end
    pulse_load();
    send_stream(0, img2, 0, 8'h01);
    checks++; if ({cpu_resetN, done, error} !== 3'b001) begin errors++; $display("FAIL empty_bad got %b exp 001", {cpu_resetN, done, error}); end
  endtask

  task automatic test_capacity();
    do_reset();
    send_byte(8'h00);
    send_byte(8'h05);
    checks++; if (error2 !== 1'b1 || rx_ready2 !== 1'b0) begin errors++; $display("FAIL cap_over got err=%0b rdy=%0b exp 1/0", error2, rx_ready2); end
    idle(2);
    checks++; if (wa2.size() != 0) begin errors++; $display("FAIL cap_over_writes got %0d exp 0", wa2.size()); end
    do_reset();
    send_stream(4, img4, 0, 8'h00);
    checks++;
    if (wa2.size() != 4) begin errors++; $display("FAIL cap_full_count got %0d exp 4", wa2.size()); end
    else if (wa2[3] !== 32'hC || wd2[3] !== 32'hCAFEF00D || wa2[0] !== 32'h0) begin
      errors++; $display("FAIL cap_full_last got %h/%h exp c/cafef00d", wa2[3], wd2[3]);
    end
    checks++; if (done2 !== 1'b1 || cpu_resetN2 !== 1'b1) begin errors++; $display("FAIL cap_full_done got %0b/%0b exp 1/1", done2, cpu_resetN2); end
  endtask

  task automatic test_stall();
    do_reset();
    send_stream(2, img2, 2, 8'h00);
    check_two_writes("stall");
    checks++; if ({cpu_resetN, done, error} !== 3'b110) begin errors++; $display("FAIL stall_status got %b exp 110", {cpu_resetN, done, error}); end
  endtask

  task automatic test_reset_midload();
    do_reset();
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h20); send_byte(8'h08); send_byte(8'h00); send_byte(8'h05);
    send_byte(8'hAC);
    idle(1);
    checks++; if (wa.size() != 1) begin errors++; $display("FAIL midrst_pre got %0d exp 1", wa.size()); end
    resetN = 1'b0; #1;
    checks++; if (mem_wdata !== 32'h0 || mem_we !== 1'b0 || rx_ready !== 1'b1) begin errors++; $display("FAIL midrst_vals got %h/%0b/%0b exp 0/0/1", mem_wdata, mem_we, rx_ready); end
    checks++; if ({cpu_resetN, done, error} !== 3'b000) begin errors++; $display("FAIL midrst_status got %b exp 000", {cpu_resetN, done, error}); end
    do_reset();
    send_stream(2, img2, 0, 8'h00);
    check_two_writes("midrst");
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL midrst_done got %0b exp 1", done); end
  endtask

  initial begin
    img2 = '{32'h20080005, 32'hAC010004, 32'h0, 32'h0};
    img4 = '{32'h00000013, 32'h11223344, 32'hDEADBEEF, 32'hCAFEF00D};
    test_reset();
    test_basic();
    test_bad_csum();
    test_empty();
    test_capacity();
    test_stall();
    test_reset_midload();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
